// File: rtl/hamming_stream_decoder_if.sv
// Stream bundle between the deframer, the Hamming(7,4) decoder and the consumer.
// Upstream side: code_in/in_valid/in_ready.
// Downstream side: data_out/syndrome/err_flag/out_valid/out_ready.
// The slave modport is the decoder's view; the master modport is the surrounding logic.
interface hamming_stream_decoder_if;
  logic [6:0] code_in;    // {d3,d2,d1,d0,p2,p1,p0}
  logic       in_valid;
  logic       in_ready;
  logic [3:0] data_out;   // {d3,d2,d1,d0}
  logic [2:0] syndrome;
  logic       err_flag;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output code_in, in_valid, out_ready,
    input  in_ready, data_out, syndrome, err_flag, out_valid
  );

  modport slave (
    input  code_in, in_valid, out_ready,
    output in_ready, data_out, syndrome, err_flag, out_valid
  );
endinterface

// File: rtl/hamming_stream_decoder.sv
// Streaming Hamming(7,4) decoder with a two-stage valid/ready pipeline.
// S1 captures the data bits and the syndrome of each accepted codeword.
// S2 holds the corrected data, syndrome and err_flag, and drives the outputs.
// Optional build macro HAMMING_DEC_STATS_EN adds saturating counters:
// word_count counts delivered words, corr_count counts corrected words.
// Without the macro both counters read 0 and clr_stats is ignored.
module hamming_stream_decoder #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  hamming_stream_decoder_if.slave  bus,
  input  logic                     clr_stats,
  output logic [CNT_WIDTH-1:0]     word_count,
  output logic [CNT_WIDTH-1:0]     corr_count
);

  // Syndrome {s2,s1,s0}. Each bit rechecks one parity equation of the encoder.
  function automatic logic [2:0] calc_syndrome(input logic [6:0] c);
    logic [2:0] s;
    s[2] = c[2] ^ c[6] ^ c[5] ^ c[4];
    s[1] = c[1] ^ c[6] ^ c[5] ^ c[3];
    s[0] = c[0] ^ c[6] ^ c[4] ^ c[3];
    return s;
  endfunction

  // Mask of the data bit that the syndrome points at.
  // Syndromes that point at parity bits leave the data untouched.
  function automatic logic [3:0] data_fix(input logic [2:0] s);
    logic [3:0] m;
    m = 4'b0000;
    case (s)
      3'b111:  m = 4'b1000;  // d3
      3'b110:  m = 4'b0100;  // d2
      3'b101:  m = 4'b0010;  // d1
      3'b011:  m = 4'b0001;  // d0
      default: m = 4'b0000;  // clean, or p2/p1/p0 flipped
    endcase
    return m;
  endfunction

  // Stage valid bits: vld_q[1] = S1 occupied, vld_q[2] = S2 occupied (out_valid).
  logic [2:1] vld_q, vld_d;

  logic [3:0] s1_data_q, s1_data_d;
  logic [2:0] s1_syn_q,  s1_syn_d;

  logic [3:0] s2_data_q, s2_data_d;
  logic [2:0] s2_syn_q,  s2_syn_d;
  logic       s2_err_q,  s2_err_d;

  logic       adv1, adv2;
  logic [2:0] syn_in;
  logic       out_fire;

  assign syn_in = calc_syndrome(bus.code_in);

  // S2 may move when it is empty or the consumer takes its word.
  // S1 may move when it is empty or S2 moves.
  assign adv2     = !vld_q[2] || bus.out_ready;
  assign adv1     = !vld_q[1] || adv2;
  assign out_fire = vld_q[2] && bus.out_ready;

  assign bus.in_ready  = adv1;
  assign bus.out_valid = vld_q[2];
  assign bus.data_out  = s2_data_q;
  assign bus.syndrome  = s2_syn_q;
  assign bus.err_flag  = s2_err_q;

  // Next-state for both stages. A stalled stage keeps its contents.
  always_comb begin
    vld_d     = vld_q;
    s1_data_d = s1_data_q;
    s1_syn_d  = s1_syn_q;
    s2_data_d = s2_data_q;
    s2_syn_d  = s2_syn_q;
    s2_err_d  = s2_err_q;

    if (adv1) begin
      vld_d[1] = bus.in_valid;
      if (bus.in_valid) begin
        s1_data_d = bus.code_in[6:3];
        s1_syn_d  = syn_in;
      end
    end

    if (adv2) begin
      vld_d[2] = vld_q[1];
      if (vld_q[1]) begin
        s2_data_d = s1_data_q ^ data_fix(s1_syn_q);
        s2_syn_d  = s1_syn_q;
        s2_err_d  = |s1_syn_q;
      end
    end
  end

  // Pipeline registers. Reset discards any words in flight and clears the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q     <= '0;
      s1_data_q <= '0;
      s1_syn_q  <= '0;
      s2_data_q <= '0;
      s2_syn_q  <= '0;
      s2_err_q  <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      s1_data_q <= s1_data_d;
      s1_syn_q  <= s1_syn_d;
      s2_data_q <= s2_data_d;
      s2_syn_q  <= s2_syn_d;
      s2_err_q  <= s2_err_d;
    end
  end

`ifdef HAMMING_DEC_STATS_EN
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0] corr_cnt_q, corr_cnt_d;

  // Saturating counters. They step on every output transfer, and clr_stats wins over a step.
  always_comb begin
    word_cnt_d = word_cnt_q;
    corr_cnt_d = corr_cnt_q;
    if (clr_stats) begin
      word_cnt_d = '0;
      corr_cnt_d = '0;
    end else if (out_fire) begin
      if (word_cnt_q != '1)
        word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
      if (s2_err_q && (corr_cnt_q != '1))
        corr_cnt_d = corr_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt_q <= '0;
      corr_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      corr_cnt_q <= corr_cnt_d;
    end
  end

  assign word_count = word_cnt_q;
  assign corr_count = corr_cnt_q;
`else
  // Statistics are not built: the counters read 0 and clr_stats has no effect.
  logic unused_stats;
  assign unused_stats = clr_stats ^ out_fire;
  assign word_count   = '0;
  assign corr_count   = '0;
`endif

endmodule

// File: tb/tb_hamming_stream_decoder.sv
// Directed bench for hamming_stream_decoder.
// A table of clean and single-flip codewords is streamed back to back.
// Hand-written sequences cover backpressure, mid-stream reset and the statistics counters.
module tb_hamming_stream_decoder;
  localparam int CW = 4;
`ifdef HAMMING_DEC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clr_stats = 1'b0;
  logic [CW-1:0] word_count, corr_count;

  hamming_stream_decoder_if bus();

  hamming_stream_decoder #(.CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .clr_stats  (clr_stats),
    .word_count (word_count),
    .corr_count (corr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] code;
    logic [3:0] data;
    logic [2:0] syn;
  } vec_t;

  vec_t       vt [130];
  logic [2:0] syntab [7];
  logic [6:0] sw_code [32];
  logic [3:0] sw_data [32];
  logic [2:0] sw_syn  [32];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    return {d, d[3]^d[2]^d[1], d[3]^d[2]^d[0], d[3]^d[1]^d[0]};
  endfunction

  // Streams sw_*[0..n-1] and compares every delivered word in order.
  // out_ready is low for the first stall_len cycles.
  task automatic run_stream(input int n, input int stall_len);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      bus.out_ready = (cyc >= stall_len);
      bus.in_valid  = (sent < n);
      bus.code_in   = (sent < n) ? sw_code[sent] : 7'd0;
      #1;
      if (cyc >= 2 && cyc < stall_len) begin
        check("stall_in_ready", bus.in_ready, 0);
        check("stall_hold", {bus.out_valid, bus.data_out, bus.syndrome}, {1'b1, sw_data[0], sw_syn[0]});
      end
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("stream_word%0d", got),
              {bus.data_out, bus.syndrome, bus.err_flag},
              {sw_data[got], sw_syn[got], |sw_syn[got]});
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      cyc++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (got < n) check("stream_timeout", got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [6:0] m;
    logic       rdy_ok;

    syntab = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b101, 3'b110, 3'b111};
    for (int d = 0; d < 16; d++) begin
      for (int f = 0; f < 8; f++) begin
        m = (f == 0) ? 7'd0 : (7'd1 << (f - 1));
        vt[d*8+f].code = enc(4'(d)) ^ m;
        vt[d*8+f].data = 4'(d);
        vt[d*8+f].syn  = (f == 0) ? 3'b000 : syntab[f-1];
      end
    end
    vt[128] = '{7'b1001011, 4'b0001, 3'b111};
    vt[129] = '{7'b0001010, 4'b0001, 3'b001};

    bus.code_in = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {bus.out_valid, bus.data_out, bus.syndrome, bus.err_flag}, 0);
    check("reset_counters", {word_count, corr_count}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);

    // Table: clean and single-flip words back to back, 2-cycle latency, 1 word/clk
    bus.out_ready = 1'b1;
    rdy_ok = 1'b1;
    for (int k = 0; k < 132; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 2)
        check($sformatf("latency_empty%0d", k), bus.out_valid, 0);
      else
        check($sformatf("vec%0d", k-2),
              {bus.out_valid, bus.data_out, bus.syndrome, bus.err_flag},
              {1'b1, vt[k-2].data, vt[k-2].syn, |vt[k-2].syn});
      if (!bus.in_ready) rdy_ok = 1'b0;
      bus.in_valid = (k < 130);
      bus.code_in  = (k < 130) ? vt[k].code : 7'd0;
    end
    check("throughput_in_ready", rdy_ok, 1);
    @(negedge clk);
    check("drain_empty", bus.out_valid, 0);

    // Mid-stream reset with both stages full
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.code_in = 7'b1111110;
    @(negedge clk);
    bus.code_in = 7'b1111111;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("full_before_reset", {bus.out_valid, bus.data_out, bus.syndrome, bus.err_flag, bus.in_ready},
          {1'b1, 4'b1111, 3'b001, 1'b1, 1'b0});
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {bus.out_valid, bus.data_out, bus.syndrome, bus.err_flag}, 0);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("no_stale%0d", k), bus.out_valid, 0);
    end

    // Backpressure: 8 words, out_ready low for 5 cycles
    for (int j = 0; j < 8; j++) begin
      logic [3:0] dl [8];
      dl = '{4'd3, 4'd5, 4'd9, 4'd12, 4'd0, 4'd15, 4'd6, 4'd10};
      sw_data[j] = dl[j];
      sw_code[j] = enc(dl[j]) ^ ((j % 2 == 1) ? (7'd1 << (j % 7)) : 7'd0);
      sw_syn[j]  = (j % 2 == 1) ? syntab[j % 7] : 3'b000;
    end
    run_stream(8, 5);

    // Statistics: 20 words, 3 corrected, counter width 4
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 20; j++) begin
      sw_data[j] = 4'(j);
      sw_code[j] = enc(4'(j)) ^ ((j == 4 || j == 9 || j == 17) ? (7'd1 << (j % 7)) : 7'd0);
      sw_syn[j]  = (j == 4 || j == 9 || j == 17) ? syntab[j % 7] : 3'b000;
    end
    run_stream(20, 0);
    check("word_count_sat", word_count, STATS ? 15 : 0);
    check("corr_count", corr_count, STATS ? 3 : 0);

    // clr_stats in the same cycle as a transfer of a corrected word
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.code_in = enc(4'd5) ^ 7'b0000100;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("clr_transfer_valid", {bus.out_valid, bus.data_out, bus.err_flag}, {1'b1, 4'd5, 1'b1});
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    check("clr_priority", {word_count, corr_count}, 0);

    // One clean word after the clear
    bus.in_valid = 1'b1; bus.code_in = enc(4'd9);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post_clr_data", {bus.out_valid, bus.data_out, bus.err_flag}, {1'b1, 4'd9, 1'b0});
    @(negedge clk);
    check("post_clr_counts", {word_count, corr_count}, {STATS ? 4'd1 : 4'd0, 4'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
